maxnet_ctrl: RTL

Iteration controller for the four-neuron MaxNet built around the PU. Latches four IEEE-754 single-precision inputs, drives them into the PU each iteration and captures the PU outputs back as the next iteration's inputs. Stops when at most one neuron remains active or an iteration cap is reached, then reports the winning index and value. It is both the upstream feeder and the downstream consumer of the PU.

---
 rtl/maxnet_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: iteration controller for the four-neuron MaxNet PU.
// Feeds a1..a4 to the PU, recaptures results, reports the survivor.
module maxnet_ctrl #(
  parameter int WIDTH    = 32,
  parameter int PU_LAT   = 1,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  x2,
  input  logic [WIDTH-1:0]  x3,
  input  logic [WIDTH-1:0]  x4,
  input  logic [WIDTH-1:0]  pu_1_out,
  input  logic [WIDTH-1:0]  pu_2_out,
  input  logic [WIDTH-1:0]  pu_3_out,
  input  logic [WIDTH-1:0]  pu_4_out,
  output logic [WIDTH-1:0]  pu_x1,
  output logic [WIDTH-1:0]  pu_x2,
  output logic [WIDTH-1:0]  pu_x3,
  output logic [WIDTH-1:0]  pu_x4,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic [WIDTH-1:0]  win_value,
  output logic              no_winner,
  output logic [ITER_W-1:0] iter_count
);

  localparam int LW = (PU_LAT < 2) ? 1 : $clog2(PU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT,
    DONE
  } state_t;

  state_t                 state;
  logic [LW-1:0]          wcnt;
  logic [3:0][WIDTH-1:0]  a;
  logic [3:0]             act;
  logic [2:0]             nact;
  logic [1:0]             widx;
  logic                   at_cap;
  logic                   one_left;
  logic                   stop_none;
  logic                   go_iter;

  assign pu_x1 = a[0];
  assign pu_x2 = a[1];
  assign pu_x3 = a[2];
  assign pu_x4 = a[3];

  // Active = strictly positive, nonzero magnitude; no float math needed.
  always_comb begin
    nact = '0;
    widx = '0;
    for (int i = 3; i >= 0; i--) begin
      act[i] = ~a[i][WIDTH-1] & (|a[i][WIDTH-2:0]);
      if (act[i]) begin
        nact = nact + 3'd1;
        widx = 2'(i);
      end
    end
  end

  assign at_cap    = (iter_count == ITER_W'(MAX_ITER));
  assign one_left  = (nact == 3'd1);
  assign stop_none = (nact == 3'd0) || ((nact > 3'd1) && at_cap);
  assign go_iter   = (nact > 3'd1) && !at_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      a          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      winner     <= '0;
      win_value  <= '0;
      no_winner  <= 1'b0;
      iter_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            a          <= {x4, x3, x2, x1};
            iter_count <= '0;
            no_winner  <= 1'b0;
            winner     <= '0;
            win_value  <= '0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          unique case (1'b1)
            one_left: begin
              winner    <= widx;
              win_value <= a[widx];
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
            stop_none: begin
              no_winner <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
            go_iter: begin
              wcnt  <= LW'(PU_LAT);
              state <= WAIT;
            end
            default: state <= CHECK;
          endcase
        end
        WAIT: begin
          wcnt <= wcnt - LW'(1);
          if (wcnt == LW'(1)) begin
            a <= {pu_4_out, pu_3_out, pu_2_out, pu_1_out};
            iter_count <= iter_count + ITER_W'(1);
            state <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
